// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests words from instruction memory, screens opcodes, issues legal ones downstream.
// Latency: ack edge to instr_valid is zero extra cycles (valid is the ISSUE state); best case one instruction per 2 cycles.
// Backpressure: imem_req holds until imem_ack; the issued instruction holds until instr_ready; illegal words are dropped.
module instr_fetch_unit #(
  parameter int              PC_W     = 8,
  parameter int              IW       = 16,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [IW-1:0]   imem_rdata,
  output logic [2:0]      control_opcode,
  output logic [IW-1:0]   instr_out,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic            illegal_op,
  output logic [PC_W-1:0] pc_out,
  output logic [7:0]      issue_count
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_REQ   = 2'b01;
  localparam logic [1:0] S_ISSUE = 2'b10;

  localparam logic [2:0] OP_JUMP = 3'b011;

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IW-1:0]   instr_q, instr_d;
  logic            illegal_q, illegal_d;
  logic [7:0]      cnt_q, cnt_d;

  // 000 and 111 are the only opcodes the control unit does not understand
  function automatic logic is_legal(input logic [2:0] op);
    return (op != 3'b000) && (op != 3'b111);
  endfunction

  // Next-state logic: fetch, screen and issue; pc only moves once an instruction is retired or dropped
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    illegal_d = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_REQ;
      end
      S_REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          if (is_legal(imem_rdata[IW-1 -: 3])) begin
            state_d = S_ISSUE;
          end else begin
            // Dropped word: flag it for one cycle and step past it
            illegal_d = 1'b1;
            pc_d      = pc_q + PC_W'(1);
            state_d   = run ? S_REQ : S_IDLE;
          end
        end
      end
      S_ISSUE: begin
        if (instr_ready) begin
          cnt_d   = cnt_q + 8'd1;
          pc_d    = (instr_q[IW-1 -: 3] == OP_JUMP) ? instr_q[PC_W-1:0] : pc_q + PC_W'(1);
          state_d = run ? S_REQ : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any in-flight instruction immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign imem_req       = (state_q == S_REQ);
  assign imem_addr      = pc_q;
  assign instr_valid    = (state_q == S_ISSUE);
  assign instr_out      = instr_q;
  assign control_opcode = instr_q[IW-1 -: 3];
  assign illegal_op     = illegal_q;
  assign pc_out         = pc_q;
  assign issue_count    = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a memory responder predicts each fetch outcome into a scoreboard queue,
// a monitor pops and compares on every issue handshake or illegal pulse, and a main thread
// sequences directed scenarios followed by randomized traffic.
module tb_instr_fetch_unit;

  localparam logic [7:0] RESET_PC = 8'h00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        run = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [2:0]  control_opcode;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        illegal_op;
  logic [7:0]  pc_out;
  logic [7:0]  issue_count;

  instr_fetch_unit #(.PC_W(8), .IW(16), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .control_opcode(control_opcode), .instr_out(instr_out), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .illegal_op(illegal_op), .pc_out(pc_out), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          illegal;
    logic [15:0] instr;
    logic [7:0]  pc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mem [0:255];
  logic [7:0]  addr_log[$];
  int          hs_cyc[$];
  int          checks = 0, failures = 0;
  int          cyc = 0, hs_count = 0, ill_count = 0, model_cnt = 0;
  bit          bench_en = 0, late_ack = 0, garbage_ack = 0, ack_rand = 0;
  int          ack_fix = 0, ready_mode = 0, stall_n = 4;
  logic [7:0]  exp_pc = RESET_PC;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_imem_req"}, 32'(imem_req), 0);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 0);
    chk({tag, "_illegal_op"}, 32'(illegal_op), 0);
    chk({tag, "_opcode"}, 32'(control_opcode), 0);
    chk({tag, "_instr_out"}, 32'(instr_out), 0);
    chk({tag, "_issue_count"}, 32'(issue_count), 0);
    chk({tag, "_pc"}, 32'(pc_out), 32'(RESET_PC));
  endtask

  // Downstream ready: always, fixed stall, or random
  initial begin : ready_drv
    int vcnt;
    vcnt = 0;
    instr_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (instr_valid) begin
        case (ready_mode)
          0:       instr_ready = 1'b1;
          1:       instr_ready = (vcnt >= stall_n);
          default: instr_ready = ($urandom_range(0, 2) != 0);
        endcase
        vcnt++;
      end else begin
        vcnt = 0;
        instr_ready = (ready_mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b0;
      end
    end
  end

  // Memory responder and reference model: each ack predicts the fetch outcome and the next pc
  initial begin : responder
    exp_t       e;
    bit         inflight;
    logic [7:0] cur_addr;
    int         wait_n;
    logic [2:0] op;
    inflight = 0;
    cur_addr = 8'h00;
    wait_n = 0;
    imem_ack = 1'b0;
    imem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (!bench_en) begin
        inflight = 0;
        exp_pc = RESET_PC;
        imem_ack = late_ack;
        imem_rdata = 16'h8000;
      end else if (imem_req) begin
        if (!inflight) begin
          chk("imem_addr", 32'(imem_addr), 32'(exp_pc));
          addr_log.push_back(imem_addr);
          inflight = 1;
          cur_addr = imem_addr;
          wait_n = ack_rand ? int'($urandom_range(0, 3)) : ack_fix;
        end else begin
          chk("addr_stable", 32'(imem_addr), 32'(cur_addr));
        end
        if (wait_n == 0) begin
          imem_ack = 1'b1;
          imem_rdata = mem[cur_addr];
          op = mem[cur_addr][15:13];
          e.illegal = (op == 3'b000) || (op == 3'b111);
          e.instr = mem[cur_addr];
          e.pc = exp_pc;
          sb.push_back(e);
          if (!e.illegal && op == 3'b011) exp_pc = mem[cur_addr][7:0];
          else exp_pc = exp_pc + 8'd1;
          inflight = 0;
        end else begin
          imem_ack = 1'b0;
          imem_rdata = 16'($urandom);
          wait_n--;
        end
      end else begin
        if (inflight) chk("req_held", 32'(imem_req), 1);
        inflight = 0;
        imem_ack = garbage_ack && ($urandom_range(0, 3) == 0);
        imem_rdata = 16'($urandom);
      end
    end
  end

  // Monitor: pops on each issue handshake or illegal pulse, checks hold-stability under backpressure
  initial begin : monitor
    exp_t        e;
    bit          prev_valid, prev_ready;
    logic [15:0] prev_instr;
    logic [2:0]  prev_op;
    prev_valid = 0;
    prev_ready = 0;
    prev_instr = 16'h0;
    prev_op = 3'h0;
    forever begin
      @(negedge clk);
      if (!bench_en) begin
        sb.delete();
        model_cnt = 0;
        prev_valid = 0;
      end else begin
        if (illegal_op) begin
          ill_count++;
          if (sb.size() == 0) chk("illegal_unexpected", 32'(illegal_op), 0);
          else begin
            e = sb.pop_front();
            chk("illegal_kind", 32'(illegal_op), 32'(e.illegal));
            chk("illegal_instr", 32'(instr_out), 32'(e.instr));
          end
        end
        if (instr_valid && instr_ready) begin
          hs_count++;
          hs_cyc.push_back(cyc);
          if (sb.size() == 0) chk("issue_unexpected", 32'(instr_valid), 0);
          else begin
            e = sb.pop_front();
            chk("issue_kind", 32'(instr_valid), 32'(!e.illegal));
            chk("issue_instr", 32'(instr_out), 32'(e.instr));
            chk("issue_opcode", 32'(control_opcode), 32'(e.instr[15:13]));
            chk("issue_pc", 32'(pc_out), 32'(e.pc));
            chk("issue_count", 32'(issue_count), 32'(model_cnt));
            model_cnt = (model_cnt + 1) % 256;
          end
        end
        if (instr_valid && prev_valid && !prev_ready) begin
          chk("hold_instr", 32'(instr_out), 32'(prev_instr));
          chk("hold_opcode", 32'(control_opcode), 32'(prev_op));
        end
        prev_valid = instr_valid;
        prev_ready = instr_ready;
        prev_instr = instr_out;
        prev_op = control_opcode;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] exp_addrs [12];
    bit ok;
    int n;
    exp_addrs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h42, 8'h07, 8'h08, 8'hFF, 8'h00, 8'h01};
    for (int i = 0; i < 256; i++) mem[i] = 16'h8000;
    mem[8'h05] = 16'h6042;
    mem[8'h42] = 16'h6007;
    mem[8'h07] = 16'hE000;
    mem[8'h08] = 16'h60FF;

    #1 rst_n = 1'b0;
    #1 check_reset("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bench_en = 1;
    run = 1'b1;
    chk("req_before_first_edge", 32'(imem_req), 0);

    // Sequential, jump, illegal and wrap with zero-wait memory and ready always high
    repeat (40) @(negedge clk);
    chk("seq_addr_count_ok", 32'(addr_log.size() >= 12), 1);
    if (addr_log.size() >= 12)
      for (int i = 0; i < 12; i++) chk($sformatf("seq_addr%0d", i), 32'(addr_log[i]), 32'(exp_addrs[i]));
    chk("hs_count_ok", 32'(hs_cyc.size() >= 4), 1);
    if (hs_cyc.size() >= 4)
      for (int i = 0; i < 3; i++) chk($sformatf("issue_gap%0d", i), 32'(hs_cyc[i+1] - hs_cyc[i]), 2);
    chk("illegal_seen", 32'(ill_count >= 1), 1);

    // Slow memory and stalled downstream
    n = hs_count;
    ack_fix = 3;
    ready_mode = 1;
    repeat (60) @(negedge clk);
    chk("stall_progress", 32'(hs_count > n), 1);

    // run dropped during a request: the instruction still issues, then idle
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr != 8'h07) ok = 1;
    end
    chk("rundrop_req_found", 32'(ok), 1);
    n = hs_count;
    run = 1'b0;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (!imem_req && !instr_valid) ok = 1;
    end
    chk("rundrop_idle", 32'(ok), 1);
    repeat (3) @(negedge clk);
    chk("rundrop_issued", 32'(hs_count), 32'(n + 1));
    chk("rundrop_req_low", 32'(imem_req), 0);
    chk("rundrop_valid_low", 32'(instr_valid), 0);

    // Reset while an instruction is waiting in ISSUE, then a stray ack
    run = 1'b1;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (instr_valid) ok = 1;
    end
    chk("midflight_valid_found", 32'(ok), 1);
    #2;
    bench_en = 0;
    rst_n = 1'b0;
    #1 check_reset("midflight");
    run = 1'b0;
    late_ack = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      chk("late_ack_req", 32'(imem_req), 0);
      chk("late_ack_valid", 32'(instr_valid), 0);
      chk("late_ack_pc", 32'(pc_out), 32'(RESET_PC));
      chk("late_ack_count", 32'(issue_count), 0);
    end
    late_ack = 0;
    @(negedge clk);

    // Randomized program, memory latency, backpressure, run and stray acks
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    ack_rand = 1;
    ready_mode = 2;
    garbage_ack = 1;
    @(negedge clk);
    bench_en = 1;
    run = 1'b1;
    chk("rand_req_before_edge", 32'(imem_req), 0);
    @(negedge clk);
    chk("rand_req_after_edge", 32'(imem_req), 1);
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      run = ($urandom_range(0, 7) != 0);
    end

    run = 1'b0;
    garbage_ack = 0;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (!imem_req && !instr_valid) ok = 1;
    end
    chk("drain_idle", 32'(ok), 1);
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameters SHALL be: PC_W, default 8, program-counter width.
REQ-002 Parameters SHALL be: IW, default 16, instruction width.
REQ-003 Parameters SHALL be: RESET_PC, default 8'h00, PC value loaded at reset.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset. Ports are listed below.
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  fetch enable.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  PC_W  read address; equals pc.
- imem_ack  in  1  read data valid; may arrive any number of cycles after the request, including the first request cycle.
- imem_rdata  in  IW  instruction word, sampled when imem_ack=1.
- control_opcode  out  3  opcode for the control unit; equals instr[15:13].
- instr_out  out  IW  captured instruction word.
- instr_valid  out  1  control_opcode and instr_out are valid.
- instr_ready  in  1  downstream accepts the instruction.
- illegal_op  out  1  one-cycle pulse when an illegal opcode is fetched.
- pc_out  out  PC_W  current pc.
- issue_count  out  8  count of issued instructions.

Function
REQ-005 Legal opcodes SHALL be: 001 load, 010 store, 011 jump, 100 add, 101 add-immediate, 110 subtract. Opcodes 000 and 111 SHALL be illegal.
REQ-006 The FSM SHALL have three states: IDLE, REQ and ISSUE. Reset state is IDLE.
REQ-007 IDLE behaviour:
- imem_req=0 and instr_valid=0.
- run=1 moves the FSM to REQ on the next edge.
REQ-008 REQ behaviour:
- imem_req=1, and imem_addr=pc held stable until imem_ack.
- On an edge with imem_ack=1 and a legal opcode: imem_rdata is captured into instr_out and the FSM moves to ISSUE.
REQ-009 On an edge in REQ with imem_ack=1 and an illegal opcode:
- instr_out is still captured.
- illegal_op=1 for exactly the next cycle.
- pc advances by 1.
- The FSM moves to REQ if run=1, otherwise to IDLE.
- Nothing is issued.
REQ-010 ISSUE behaviour:
- instr_valid=1.
- control_opcode and instr_out held stable until instr_ready=1.
- imem_req=0.
REQ-011 Handshake completes on an edge with instr_valid=1 and instr_ready=1. The FSM then moves to REQ if run=1, otherwise to IDLE. issue_count increments, wrapping from 8'hFF to 8'h00.
REQ-012 PC update at handshake:
- Opcode 011 (jump): pc <= instr_out[PC_W-1:0].
- Otherwise: pc <= pc+1, modulo 2^PC_W; 8'hFF wraps to 8'h00.
REQ-013 Deasserting run in REQ or ISSUE SHALL NOT abort the transaction:
- The outstanding request completes.
- A legal instruction is issued.
- The FSM then enters IDLE.
REQ-014 imem_req SHALL NOT be deasserted before imem_ack, except by reset.
REQ-015 An imem_ack arriving outside REQ SHALL be ignored.
REQ-016 Timing and throughput:
- Best-case throughput is one instruction per 2 cycles: ack in the first REQ cycle and ready in the first ISSUE cycle.
- Latency from the ack edge to instr_valid=1 is 0 cycles after that edge, because valid is registered with the ISSUE state.
REQ-017 pc_out SHALL always equal the internal pc, and imem_addr SHALL equal pc whenever imem_req=1.

Reset
REQ-018 rst_n=0 SHALL immediately, without waiting for a clock edge, set the outputs as follows:
- FSM state=IDLE and pc=RESET_PC.
- imem_req=0 and instr_valid=0.
- illegal_op=0.
- control_opcode=3'b000 and instr_out=0.
- issue_count=0.
REQ-019 Reset asserted mid-transaction (in REQ or ISSUE) SHALL discard the in-flight instruction. Any later imem_ack for it is ignored per REQ-015.
REQ-020 After rst_n rises, the first imem_req SHALL appear no earlier than one cycle after the first edge with run=1.

Verification
REQ-021 The bench SHALL cover the following directed scenarios, each with its required response:
- Sequential fetch: reset, run=1, imem returns 16'h8000 (add) at each address with ack in the first request cycle, ready=1. Required: addresses 00,01,02,03; instr_valid every 2nd cycle; control_opcode=3'b100; issue_count=4 after 4 handshakes.
- Jump: instruction 16'h6042 fetched at pc=05. Required: control_opcode=3'b011 issued; next imem_addr=8'h42.
- Illegal opcode: 16'hE000 at pc=07. Required: illegal_op pulses for 1 cycle; no instr_valid; next imem_addr=8'h08; issue_count unchanged.
- Stall and latency: ack delayed 3 cycles and instr_ready held 0 for 4 cycles. Required: imem_req and imem_addr stable through the wait; control_opcode/instr_out stable while valid=1 and ready=0.
- Wrap: pc=8'hFF, non-jump instruction issued. Required: next imem_addr=8'h00.
- Reset mid-flight and run drop: rst_n=0 while in ISSUE gives immediate instr_valid=0, pc=00, and a late ack ignored. run=0 during REQ completes and issues that instruction, then returns to IDLE with imem_req=0.
